vga_fb_reader: RTL and testbench



---
 rtl/vga_fb_reader.sv | 154 +++++++++++++++
 tb/tb_vga_fb_reader.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_reader.sv
// VGA read side of the pixel frame buffer: generates 640x480@60 timing and fetches each
// visible pixel from a 160x120 buffer, upscaled by 1<<SCALE_LOG2 in both axes.
// Pipeline: stage 0 registers the fetch (address/strobe) together with raw sync flags;
// stage 1 registers active/sync one clock later, aligned with the buffer's read data.
module vga_fb_reader #(
    parameter int unsigned AW         = 15,
    parameter int unsigned DW         = 3,
    parameter int unsigned FB_W       = 160,
    parameter int unsigned FB_H       = 120,
    parameter int unsigned SCALE_LOG2 = 2,
    parameter int unsigned H_VIS      = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_VIS      = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          SYNC_POL   = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] mem_px_addr,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_px_data,
    output logic          vga_hsync,
    output logic          vga_vsync,
    output logic          vga_r,
    output logic          vga_g,
    output logic          vga_b,
    output logic          active,
    output logic          frame_start
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW    = $clog2(H_TOT);
    localparam int unsigned VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
    localparam logic [HW-1:0] H_VIS_C    = HW'(H_VIS);
    localparam logic [VW-1:0] V_VIS_C    = VW'(V_VIS);
    localparam logic [HW-1:0] HS_START   = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START   = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_VIS + V_FP + V_SYNC);
    // Base address of the last buffer row; the row base parks here through vertical blanking.
    localparam logic [AW-1:0] ROW_LAST   = AW'((FB_H - 1) * FB_W);
    localparam logic [AW-1:0] ROW_STRIDE = AW'(FB_W);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [AW-1:0] row_base_q, row_base_d;

    logic          mem_rd_q, mem_rd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          hs0_q, hs0_d;
    logic          vs0_q, vs0_d;
    logic          fs0_q, fs0_d;

    logic          active_q, active_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          frame_start_q, frame_start_d;

    logic          vis0;
    logic [AW-1:0] col;

    // Raster counters and the incrementally maintained row base address.
    always_comb begin
        h_cnt_d    = h_cnt_q + HW'(1);
        v_cnt_d    = v_cnt_q;
        row_base_d = row_base_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d    = '0;
                row_base_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + VW'(1);
                // Advance one buffer row after the last of its replicated display lines.
                if ((&v_cnt_q[SCALE_LOG2-1:0]) && (row_base_q != ROW_LAST)) begin
                    row_base_d = row_base_q + ROW_STRIDE;
                end
            end
        end
    end

    // Stage 0: fetch request plus raw sync/frame flags for the current counter value.
    always_comb begin
        vis0     = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
        col      = AW'(h_cnt_q >> SCALE_LOG2);
        mem_rd_d = vis0;
        addr_d   = vis0 ? (row_base_q + col) : '0;
        hs0_d    = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        vs0_d    = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
        fs0_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Stage 1: everything delayed once more so it lines up with the buffer read data.
    always_comb begin
        active_d      = mem_rd_q;
        hsync_d       = hs0_q ? SYNC_POL : ~SYNC_POL;
        vsync_d       = vs0_q ? SYNC_POL : ~SYNC_POL;
        frame_start_d = fs0_q;
    end

    // State registers; reset returns the whole raster to the top-left immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            row_base_q    <= '0;
            mem_rd_q      <= 1'b0;
            addr_q        <= '0;
            hs0_q         <= 1'b0;
            vs0_q         <= 1'b0;
            fs0_q         <= 1'b0;
            active_q      <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            row_base_q    <= row_base_d;
            mem_rd_q      <= mem_rd_d;
            addr_q        <= addr_d;
            hs0_q         <= hs0_d;
            vs0_q         <= vs0_d;
            fs0_q         <= fs0_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Buffer data is already registered by the read port; only blank-gating happens here.
    always_comb begin
        vga_r = active_q & mem_px_data[2];
        vga_g = active_q & mem_px_data[1];
        vga_b = active_q & mem_px_data[0];
    end

    assign mem_px_addr = addr_q;
    assign mem_rd      = mem_rd_q;
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign active      = active_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Self-checking bench for vga_fb_reader on a reduced raster geometry (same scale factor,
// same sync structure) so several whole frames fit in a short run.
module tb_vga_fb_reader;

    localparam int AW     = 6;
    localparam int FB_W   = 10;
    localparam int FB_H   = 6;
    localparam int SCL2   = 2;
    localparam int SCALE  = 1 << SCL2;
    localparam int H_VIS  = FB_W * SCALE;
    localparam int H_FP   = 4;
    localparam int H_SYNC = 6;
    localparam int H_BP   = 6;
    localparam int V_VIS  = FB_H * SCALE;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 3;
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME  = H_TOT * V_TOT;
    localparam int NPIX   = FB_W * FB_H;

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic          act;
        logic          hs;
        logic          vs;
        logic          fs;
        logic [2:0]    rgb;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] mem_px_addr;
    logic          mem_rd;
    logic [2:0]    mem_px_data;
    logic          vga_hsync, vga_vsync, vga_r, vga_g, vga_b, active, frame_start;

    logic [2:0]    fb [NPIX];
    logic [2:0]    rdata = 3'b000;
    bit            white = 1'b0;
    int            n = 0;
    int            tests_run = 0;
    int            tests_failed = 0;
    exp_t          obs;

    vga_fb_reader #(
        .AW(AW), .DW(3), .FB_W(FB_W), .FB_H(FB_H), .SCALE_LOG2(SCL2),
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .mem_px_addr(mem_px_addr), .mem_rd(mem_rd),
        .mem_px_data(mem_px_data), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .active(active),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Synchronous-read buffer model with one clock of latency; white forces the data bus.
    always @(posedge clk) if (mem_rd) rdata <= fb[mem_px_addr];
    assign mem_px_data = white ? 3'b111 : rdata;

    // Clock edges seen since reset release.
    always @(posedge clk or posedge rst) if (rst) n <= 0; else n <= n + 1;

    assign obs = {mem_rd, mem_px_addr, active, vga_hsync, vga_vsync, frame_start,
                  vga_r, vga_g, vga_b};

    // Expected pins after edge k: fetch reflects raster position k-1, display reflects k-2.
    function automatic exp_t model(input int k);
        exp_t e;
        int p, h, v;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (k >= 1) begin
            p = (k - 1) % FRAME; h = p % H_TOT; v = p / H_TOT;
            e.rd   = (h < H_VIS) && (v < V_VIS);
            e.addr = e.rd ? AW'((v / SCALE) * FB_W + h / SCALE) : '0;
        end
        if (k >= 2) begin
            p = (k - 2) % FRAME; h = p % H_TOT; v = p / H_TOT;
            e.act = (h < H_VIS) && (v < V_VIS);
            e.hs  = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC));
            e.vs  = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC));
            e.fs  = (p == 0);
            e.rgb = !e.act ? 3'b000 : (white ? 3'b111 : fb[(v / SCALE) * FB_W + h / SCALE]);
        end
        return e;
    endfunction

    // Advance to the negedge where the fetch stage holds raster position pos.
    task automatic goto_pos(input int pos, input string tag);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(n >= 1 && (n - 1) % FRAME == pos) && guard < 2 * FRAME + 4);
        tests_run++;
        if (!(n >= 1 && (n - 1) % FRAME == pos)) begin
            tests_failed++;
            $display("FAIL %s wait: position %0d not reached, edge count %0d", tag, pos, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if (obs !== model(0)) begin
            tests_failed++;
            $display("FAIL reset_state: got %h want %h", obs, model(0));
        end
        tests_run++;
        if (vga_hsync !== 1'b1 || vga_vsync !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_sync: got %b%b want 11", vga_hsync, vga_vsync);
        end
    endtask

    task automatic test_first_pixels();
        exp_t e;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            e = model(n);
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL first_pixels n=%0d: got %h want %h", n, obs, e);
            end
            if (n == 1) begin
                tests_run++;
                if (mem_rd !== 1'b1 || mem_px_addr !== '0 || frame_start !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL first_fetch: rd=%b addr=%0d fs=%b want rd=1 addr=0 fs=0",
                             mem_rd, mem_px_addr, frame_start);
                end
            end
            if (n == 2) begin
                tests_run++;
                if (frame_start !== 1'b1 || active !== 1'b1 || {vga_r, vga_g, vga_b} !== 3'b000)
                begin
                    tests_failed++;
                    $display("FAIL first_pixel: fs=%b act=%b rgb=%b want 1 1 000",
                             frame_start, active, {vga_r, vga_g, vga_b});
                end
            end
            if (n >= 6 && n <= 9) begin
                tests_run++;
                if ({vga_r, vga_g, vga_b} !== 3'b001) begin
                    tests_failed++;
                    $display("FAIL pixel_%0d: rgb=%b want 001", n - 2, {vga_r, vga_g, vga_b});
                end
            end
        end
    endtask

    task automatic test_addr_points();
        logic [AW-1:0] want;
        goto_pos(3 * H_TOT + 8, "line3");
        want = AW'(2);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (mem_px_addr !== want || mem_rd !== 1'b1) begin
                tests_failed++;
                $display("FAIL addr_line3 h=%0d: got %0d want %0d", 8 + i, mem_px_addr, want);
            end
            @(negedge clk);
        end
        goto_pos(4 * H_TOT + 8, "line4");
        want = AW'(FB_W + 2);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (mem_px_addr !== want || mem_rd !== 1'b1) begin
                tests_failed++;
                $display("FAIL addr_line4 h=%0d: got %0d want %0d", 8 + i, mem_px_addr, want);
            end
            @(negedge clk);
        end
        goto_pos((V_VIS - 1) * H_TOT + H_VIS - 1, "last_pixel");
        want = AW'(NPIX - 1);
        tests_run++;
        if (mem_px_addr !== want || mem_rd !== 1'b1) begin
            tests_failed++;
            $display("FAIL addr_max: got %0d want %0d", mem_px_addr, want);
        end
        @(negedge clk);
        tests_run++;
        if (mem_rd !== 1'b0 || mem_px_addr !== '0) begin
            tests_failed++;
            $display("FAIL fetch_hblank: rd=%b addr=%0d want 0 0", mem_rd, mem_px_addr);
        end
        tests_run++;
        if (active !== 1'b1 || {vga_r, vga_g, vga_b} !== 3'(NPIX - 1)) begin
            tests_failed++;
            $display("FAIL last_col_shown: act=%b rgb=%b want 1 %b", active,
                     {vga_r, vga_g, vga_b}, 3'(NPIX - 1));
        end
        @(negedge clk);
        tests_run++;
        if (active !== 1'b0 || {vga_r, vga_g, vga_b} !== 3'b000) begin
            tests_failed++;
            $display("FAIL after_last_col: act=%b rgb=%b want 0 000", active,
                     {vga_r, vga_g, vga_b});
        end
    endtask

    task automatic test_full_frame();
        exp_t e;
        logic ph, pv, pf;
        int   fs_n[$], hf[$], hr[$], vf[$], vr[$];
        int   got, want;
        goto_pos(0, "full_frame");
        ph = vga_hsync; pv = vga_vsync; pf = frame_start;
        for (int i = 0; i < 2 * FRAME + 8; i++) begin
            @(negedge clk);
            e = model(n);
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL full_frame n=%0d: got %h want %h", n, obs, e);
            end
            if (frame_start && !pf) fs_n.push_back(n);
            if (!vga_hsync && ph) hf.push_back(n);
            if (vga_hsync && !ph) hr.push_back(n);
            if (!vga_vsync && pv) vf.push_back(n);
            if (vga_vsync && !pv) vr.push_back(n);
            ph = vga_hsync; pv = vga_vsync; pf = frame_start;
        end
        tests_run++;
        if (fs_n.size() < 2 || hf.size() < 2 || vf.size() < 1 || vr.size() < 1) begin
            tests_failed++;
            $display("FAIL timing_edges: fs=%0d hfall=%0d vfall=%0d vrise=%0d, want >=2 2 1 1",
                     fs_n.size(), hf.size(), vf.size(), vr.size());
        end else begin
            tests_run++;
            if (fs_n[1] - fs_n[0] != FRAME) begin
                tests_failed++;
                $display("FAIL frame_period: got %0d want %0d", fs_n[1] - fs_n[0], FRAME);
            end
            tests_run++;
            if (hf[1] - hf[0] != H_TOT) begin
                tests_failed++;
                $display("FAIL hsync_period: got %0d want %0d", hf[1] - hf[0], H_TOT);
            end
            got = -1;
            foreach (hr[j]) if (got < 0 && hr[j] > hf[0]) got = hr[j] - hf[0];
            tests_run++;
            if (got != H_SYNC) begin
                tests_failed++;
                $display("FAIL hsync_width: got %0d want %0d", got, H_SYNC);
            end
            got = -1;
            foreach (hf[j]) if (got < 0 && hf[j] > fs_n[0]) got = hf[j] - fs_n[0];
            want = H_VIS + H_FP;
            tests_run++;
            if (got != want) begin
                tests_failed++;
                $display("FAIL hsync_offset: got %0d want %0d", got, want);
            end
            want = (V_VIS + V_FP) * H_TOT;
            tests_run++;
            if (vf[0] - fs_n[0] != want) begin
                tests_failed++;
                $display("FAIL vsync_offset: got %0d want %0d", vf[0] - fs_n[0], want);
            end
            got = -1;
            foreach (vr[j]) if (got < 0 && vr[j] > vf[0]) got = vr[j] - vf[0];
            tests_run++;
            if (got != V_SYNC * H_TOT) begin
                tests_failed++;
                $display("FAIL vsync_width: got %0d want %0d", got, V_SYNC * H_TOT);
            end
        end
    endtask

    task automatic test_blanking();
        exp_t e;
        goto_pos(0, "blanking");
        white = 1'b1;
        for (int i = 0; i < FRAME + 2; i++) begin
            @(negedge clk);
            e = model(n);
            tests_run++;
            if (active !== e.act || {vga_r, vga_g, vga_b} !== (e.act ? 3'b111 : 3'b000)) begin
                tests_failed++;
                $display("FAIL blank_rgb n=%0d: act=%b rgb=%b want %b %b", n, active,
                         {vga_r, vga_g, vga_b}, e.act, e.act ? 3'b111 : 3'b000);
            end
            if (!e.rd) begin
                tests_run++;
                if (mem_rd !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL blank_rd n=%0d: got %b want 0", n, mem_rd);
                end
            end
        end
        white = 1'b0;
    endtask

    task automatic test_mid_write();
        int p, h, v;
        goto_pos(15 * H_TOT + 5, "mid_write");
        fb[0] = 3'b111;
        goto_pos(0, "mid_write_next");
        for (int i = 0; i < 5 * H_TOT; i++) begin
            @(negedge clk);
            p = (n - 2) % FRAME; h = p % H_TOT; v = p / H_TOT;
            if (v < 4 && h < 4) begin
                tests_run++;
                if ({vga_r, vga_g, vga_b} !== 3'b111) begin
                    tests_failed++;
                    $display("FAIL white_block (%0d,%0d): rgb=%b want 111", h, v,
                             {vga_r, vga_g, vga_b});
                end
            end else if (v == 4 && h < 4) begin
                tests_run++;
                if ({vga_r, vga_g, vga_b} !== 3'(FB_W)) begin
                    tests_failed++;
                    $display("FAIL below_block (%0d,%0d): rgb=%b want %b", h, v,
                             {vga_r, vga_g, vga_b}, 3'(FB_W));
                end
            end
        end
        fb[0] = 3'b000;
    endtask

    task automatic test_async_reset();
        goto_pos(12 * H_TOT + 30, "async_reset");
        tests_run++;
        if (active !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_active: got %b want 1", active);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (obs !== model(0)) begin
            tests_failed++;
            $display("FAIL async_reset_state: got %h want %h", obs, model(0));
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (mem_rd !== 1'b1 || mem_px_addr !== '0 || frame_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL rerun_fetch: rd=%b addr=%0d fs=%b want 1 0 0", mem_rd,
                     mem_px_addr, frame_start);
        end
        @(negedge clk);
        tests_run++;
        if (frame_start !== 1'b1 || active !== 1'b1 || obs !== model(n)) begin
            tests_failed++;
            $display("FAIL rerun_frame_start: fs=%b act=%b got %h want %h", frame_start,
                     active, obs, model(n));
        end
        @(negedge clk);
        tests_run++;
        if (frame_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_start_width: got %b want 0", frame_start);
        end
    endtask

    initial begin
        for (int k = 0; k < NPIX; k++) fb[k] = 3'(k);
        repeat (3) @(negedge clk);
        test_reset();
        test_first_pixels();
        test_addr_points();
        test_full_frame();
        test_blanking();
        test_mid_write();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
